// File: rtl/parking_occupancy_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : parking_occupancy_tracker                                        |
// | Purpose : two-beam direction decode, saturating occupancy, entry tally     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module parking_occupancy_tracker #(
   parameter int WIDTH     = 5,
   parameter int CAPACITY  = 25,
   parameter int TOT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sensor_a,
   input  logic                 sensor_b,
   input  logic                 adj_inc,
   input  logic                 adj_dec,
   input  logic                 err_clear,
   output logic [WIDTH-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic                 enter_pulse,
   output logic                 exit_pulse,
   output logic                 overflow_err,
   output logic                 underflow_err,
   output logic [TOT_WIDTH-1:0] total_entries
);

   localparam int SW = WIDTH + 2;
   localparam logic signed [SW-1:0] c_cap = SW'(CAPACITY);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      EN1  = 3'd1,
      EN2  = 3'd2,
      EN3  = 3'd3,
      EX1  = 3'd4,
      EX2  = 3'd5,
      EX3  = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            w_ab;
   logic                  w_enter_evt;
   logic                  w_exit_evt;
   logic signed [SW-1:0]  w_delta;
   logic signed [SW-1:0]  w_sum;
   logic                  w_clamp_hi;
   logic                  w_clamp_lo;
   logic [WIDTH-1:0]      w_count_next;

   logic [WIDTH-1:0]      r_count;
   logic [TOT_WIDTH-1:0]  r_total;
   logic                  r_enter_pulse;
   logic                  r_exit_pulse;
   logic                  r_ovf;
   logic                  r_udf;

   assign w_ab = {sensor_a, sensor_b};

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_enter_evt = 1'b0;
      w_exit_evt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ab == 2'b10)      w_next = EN1;
            else if (w_ab == 2'b01) w_next = EX1;
         end
         EN1: begin
            if (w_ab == 2'b11)      w_next = EN2;
            else if (w_ab != 2'b10) w_next = IDLE;
         end
         EN2: begin
            case (w_ab)
               2'b01:   w_next = EN3;
               2'b10:   w_next = EN1;
               2'b00:   w_next = IDLE;
               default: w_next = EN2;
            endcase
         end
         EN3: begin
            case (w_ab)
               2'b11:   w_next = EN2;
               2'b10:   w_next = IDLE;
               2'b00: begin
                  w_next      = IDLE;
                  w_enter_evt = 1'b1;
               end
               default: w_next = EN3;
            endcase
         end
         EX1: begin
            if (w_ab == 2'b11)      w_next = EX2;
            else if (w_ab != 2'b01) w_next = IDLE;
         end
         EX2: begin
            case (w_ab)
               2'b10:   w_next = EX3;
               2'b01:   w_next = EX1;
               2'b00:   w_next = IDLE;
               default: w_next = EX2;
            endcase
         end
         EX3: begin
            case (w_ab)
               2'b11:   w_next = EX2;
               2'b01:   w_next = IDLE;
               2'b00: begin
                  w_next     = IDLE;
                  w_exit_evt = 1'b1;
               end
               default: w_next = EX3;
            endcase
         end
         default: w_next = IDLE;
      endcase
   end

   // Signed sum is wide enough that count + 2 and 0 - 2 never wrap.
   always_comb begin
      w_delta = '0;
      if (w_enter_evt) w_delta = w_delta + SW'(1);
      if (adj_inc)     w_delta = w_delta + SW'(1);
      if (w_exit_evt)  w_delta = w_delta - SW'(1);
      if (adj_dec)     w_delta = w_delta - SW'(1);
      w_sum      = $signed({2'b00, r_count}) + w_delta;
      w_clamp_hi = (w_sum > c_cap);
      w_clamp_lo = w_sum[SW-1];
      if (w_clamp_hi)      w_count_next = WIDTH'(CAPACITY);
      else if (w_clamp_lo) w_count_next = '0;
      else                 w_count_next = w_sum[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count       <= '0;
         r_total       <= '0;
         r_enter_pulse <= 1'b0;
         r_exit_pulse  <= 1'b0;
         r_ovf         <= 1'b0;
         r_udf         <= 1'b0;
      end else begin
         r_count       <= w_count_next;
         r_total       <= r_total + TOT_WIDTH'(w_enter_evt);
         r_enter_pulse <= w_enter_evt;
         r_exit_pulse  <= w_exit_evt;
         // A clamp in the same cycle as err_clear keeps the flag set.
         r_ovf         <= (r_ovf & ~err_clear) | w_clamp_hi;
         r_udf         <= (r_udf & ~err_clear) | w_clamp_lo;
      end
   end

   assign count         = r_count;
   assign total_entries = r_total;
   assign enter_pulse   = r_enter_pulse;
   assign exit_pulse    = r_exit_pulse;
   assign overflow_err  = r_ovf;
   assign underflow_err = r_udf;
   assign full          = (r_count == WIDTH'(CAPACITY));
   assign empty         = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_parking_occupancy_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_parking_occupancy_tracker                                     |
// | Purpose : scoreboard bench for parking_occupancy_tracker                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_parking_occupancy_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sensor_a = 1'b0;
   logic        sensor_b = 1'b0;
   logic        adj_inc = 1'b0;
   logic        adj_dec = 1'b0;
   logic        err_clear = 1'b0;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        enter_pulse;
   logic        exit_pulse;
   logic        overflow_err;
   logic        underflow_err;
   logic [15:0] total_entries;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        kind;   // 1 = enter, 0 = exit
      logic [4:0]  cnt;
      logic [15:0] tot;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t sb[$];

   parking_occupancy_tracker #(.WIDTH(5), .CAPACITY(25), .TOT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
      .adj_inc(adj_inc), .adj_dec(adj_dec), .err_clear(err_clear),
      .count(count), .full(full), .empty(empty),
      .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
      .overflow_err(overflow_err), .underflow_err(underflow_err),
      .total_entries(total_entries)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every pulse pops one expected record.
   always @(negedge clk) begin
      if (!reset && (enter_pulse || exit_pulse)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got enter=%0b exit=%0b expected none",
                     enter_pulse, exit_pulse);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_enter", int'(enter_pulse), int'(e.kind));
            check("pulse_exit", int'(exit_pulse), int'(!e.kind));
            check("pulse_count", int'(count), int'(e.cnt));
            check("pulse_total", int'(total_entries), int'(e.tot));
            check("pulse_ovf", int'(overflow_err), int'(e.ovf));
            check("pulse_udf", int'(underflow_err), int'(e.udf));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic [1:0] ab, input int n);
      {sensor_a, sensor_b} = ab;
      repeat (n) tick();
   endtask

   task automatic expect_pulse(input logic k, input int c, input int t,
                               input logic o, input logic u);
      exp_t e;
      e.kind = k; e.cnt = 5'(c); e.tot = 16'(t); e.ovf = o; e.udf = u;
      sb.push_back(e);
   endtask

   task automatic car(input logic enter, input logic dec, input logic clr);
      hold(2'b00, 2);
      hold(enter ? 2'b10 : 2'b01, 2);
      hold(2'b11, 2);
      hold(enter ? 2'b01 : 2'b10, 2);
      {sensor_a, sensor_b} = 2'b00;
      adj_dec   = dec;
      err_clear = clr;
      tick();
      adj_dec   = 1'b0;
      err_clear = 1'b0;
      tick();
   endtask

   task automatic adj(input logic inc, input logic dec);
      adj_inc = inc;
      adj_dec = dec;
      tick();
      adj_inc = 1'b0;
      adj_dec = 1'b0;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clk);
      check({tag, "_count"}, int'(count), 0);
      check({tag, "_total"}, int'(total_entries), 0);
      check({tag, "_empty"}, int'(empty), 1);
      check({tag, "_full"}, int'(full), 0);
      check({tag, "_ovf"}, int'(overflow_err), 0);
      check({tag, "_udf"}, int'(underflow_err), 0);
      check({tag, "_pulses"}, int'({enter_pulse, exit_pulse}), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      check_reset_state("reset");

      // Basic entry and exit
      expect_pulse(1'b1, 1, 1, 1'b0, 1'b0);
      car(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("after_entry_empty", int'(empty), 0);
      expect_pulse(1'b0, 0, 1, 1'b0, 1'b0);
      car(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("after_exit_empty", int'(empty), 1);
      expect_pulse(1'b0, 0, 1, 1'b0, 1'b1);
      car(1'b0, 1'b0, 1'b0);
      pulse_clear();
      @(negedge clk);
      check("udf_cleared", int'(underflow_err), 0);

      // Aborted entry and pedestrian: no pulses expected
      hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 2);
      hold(2'b10, 2); hold(2'b00, 2);
      @(negedge clk);
      check("abort_count", int'(count), 0);
      check("abort_total", int'(total_entries), 1);

      // Fill to capacity, then overflow
      for (int i = 0; i < 25; i++) begin
         expect_pulse(1'b1, i + 1, i + 2, 1'b0, 1'b0);
         car(1'b1, 1'b0, 1'b0);
      end
      @(negedge clk);
      check("full_at_cap", int'(full), 1);
      check("cap_count", int'(count), 25);
      expect_pulse(1'b1, 25, 27, 1'b1, 1'b0);
      car(1'b1, 1'b0, 1'b0);
      pulse_clear();
      @(negedge clk);
      check("ovf_cleared", int'(overflow_err), 0);
      // Clamp coincident with err_clear: set wins
      expect_pulse(1'b1, 25, 28, 1'b1, 1'b0);
      car(1'b1, 1'b0, 1'b1);
      @(negedge clk);
      check("ovf_set_wins", int'(overflow_err), 1);
      pulse_clear();
      @(negedge clk);
      check("ovf_cleared2", int'(overflow_err), 0);

      // Attendant corrections
      do_reset();
      repeat (5) adj(1'b1, 1'b0);
      @(negedge clk);
      check("adj_to_5", int'(count), 5);
      adj(1'b1, 1'b0);
      @(negedge clk);
      check("adj_inc", int'(count), 6);
      adj(1'b1, 1'b1);
      @(negedge clk);
      check("adj_cancel", int'(count), 6);
      expect_pulse(1'b1, 6, 1, 1'b0, 1'b0);
      car(1'b1, 1'b1, 1'b0);
      adj(1'b0, 1'b1);
      @(negedge clk);
      check("adj_dec", int'(count), 5);
      expect_pulse(1'b0, 3, 1, 1'b0, 1'b0);
      car(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("exit_plus_dec", int'(count), 3);

      // Reset while in EN2 abandons the car
      hold(2'b00, 2); hold(2'b10, 2); hold(2'b11, 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("midreset");
      hold(2'b01, 2); hold(2'b00, 2);
      @(negedge clk);
      check("midreset_total", int'(total_entries), 0);
      check("midreset_count2", int'(count), 0);

      tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
